uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit-side holding buffer directly upstream of the UART transmitter. Bus/host writes bytes in; the Tx state machine pops them via its FIFO read strobe. First-word-fall-through (FWFT) buffer with occupancy count, full/empty flags, a sticky overflow/underflow status and a low-watermark interrupt for refill.

Parameters:
DATA_W, 8, payload width in bits
ADDR_W, 4, pointer width; depth = 2**ADDR_W (16 entries)

Ports:
glb_clk  input  1  system clock; all logic on rising edge
glb_rst  input  1  asynchronous, active-high reset
Bus_data_wdata  input  DATA_W  byte to enqueue
Bus_ctrl_w_en  input  1  write strobe, one entry per high cycle
Cfg_ctrl_flush  input  1  synchronous clear of contents
Cfg_ctrl_err_clr  input  1  clears sticky error flags
Cfg_ctrl_thresh  input  ADDR_W+1  low-watermark level
FIFO_data_payload  output  DATA_W  head entry (FWFT), to transmitter
FIFO_ctrl_empty  output  1  no valid entry
STM_ctrl_FIFO_r_en  input  1  pop strobe from Tx state machine
FIFO_ctrl_full  output  1  count == 2**ADDR_W
FIFO_ctrl_count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
FIFO_ctrl_overflow  output  1  sticky: write attempted while full
FIFO_ctrl_underflow  output  1  sticky: pop attempted while empty
Int_tx_low  output  1  registered, high while count <= Cfg_ctrl_thresh

Behaviour:
- Interface: one clock (glb_clk); reset glb_rst is asynchronous and active-high.
- Reset: wr_ptr=rd_ptr=0, count=0, FIFO_ctrl_empty=1, FIFO_ctrl_full=0, overflow=underflow=0, FIFO_data_payload=0, Int_tx_low=1. Storage array not reset.
- Storage: 2**ADDR_W x DATA_W register array; pointers ADDR_W bits, wrap naturally from 2**ADDR_W-1 to 0.
- Write accepted = Bus_ctrl_w_en & (~full | pop_accepted). Data stored at wr_ptr, wr_ptr+1.
- Pop accepted = STM_ctrl_FIFO_r_en & ~empty. rd_ptr+1.
- count next = count + write_acc - pop_acc; full/empty/count all registered, consistent with each other every cycle.
- FWFT: FIFO_data_payload = mem[rd_ptr] whenever empty=0; value is don't-care when empty. Transmitter samples payload in the same cycle it asserts r_en.
- Latency: write in cycle N -> empty deasserts and payload valid in cycle N+1. Pop in cycle N -> next entry on payload in cycle N+1.
- Simultaneous write+pop, count in 1..2**ADDR_W-1: both accepted, count unchanged.
- Simultaneous write+pop when full: both accepted (pop frees the slot); no overflow.
- Simultaneous write+pop when empty: write accepted, pop rejected, underflow set; count -> 1.
- Write when full without pop: dropped, contents unchanged, overflow set.
- Errors sticky until Cfg_ctrl_err_clr; if a new error and clr coincide, set wins.
- Flush: has priority over read/write in same cycle; next cycle pointers=0, count=0, empty=1, full=0; error flags untouched.
- Int_tx_low: registered compare of next count against Cfg_ctrl_thresh; thresh=0 means interrupt only when empty.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clock.

Test Plan:
- Reset, then write 0xA5 in cycle N -> empty=0, payload=0xA5, count=1 in cycle N+1; pop -> empty=1, count=0.
- Write 16 bytes 0x00..0x0F back-to-back -> full=1, count=16; 17th write 0xFF -> dropped, overflow=1; pop 16 -> outputs 0x00..0x0F in order, no 0xFF.
- At full, assert write 0x55 and pop same cycle -> count stays 16, overflow=0, 0x55 emerges as 16th pop.
- Empty FIFO, write 0x3C and pop same cycle -> underflow=1, count=1, payload=0x3C; err_clr -> underflow=0.
- Fill 10 entries, thresh=4 -> Int_tx_low=0; pop 6 -> Int_tx_low=1 once count=4; flush with simultaneous write -> count=0, empty=1.
- Wrap test: 40 writes interleaved with pops at count 3..8 -> ordering preserved across pointer wrap; assert glb_rst mid-stream -> empty=1, count=0 asynchronously.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit holding buffer in front of the UART transmitter. The host writes
//   bytes in; the Tx state machine reads them out first-word-fall-through,
//   sampling FIFO_data_payload in the same cycle it raises its read strobe.
//   Occupancy, full/empty, sticky overflow/underflow and a low-watermark
//   interrupt are all registered.
//
// Ports
//   glb_clk              system clock, rising edge
//   glb_rst              asynchronous active-high reset
//   Bus_data_wdata       byte to enqueue
//   Bus_ctrl_w_en        write strobe, one entry per high cycle
//   Cfg_ctrl_flush       synchronous clear of contents (wins over rd/wr)
//   Cfg_ctrl_err_clr     clears sticky error flags
//   Cfg_ctrl_thresh      low-watermark level
//   FIFO_data_payload    head entry (FWFT), zero while empty
//   FIFO_ctrl_empty      no valid entry
//   STM_ctrl_FIFO_r_en   pop strobe from the Tx state machine
//   FIFO_ctrl_full       occupancy == depth
//   FIFO_ctrl_count      occupancy, 0..depth
//   FIFO_ctrl_overflow   sticky: write attempted while full
//   FIFO_ctrl_underflow  sticky: pop attempted while empty
//   Int_tx_low           high while occupancy <= Cfg_ctrl_thresh
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              glb_clk,
  input  logic              glb_rst,
  input  logic [DATA_W-1:0] Bus_data_wdata,
  input  logic              Bus_ctrl_w_en,
  input  logic              Cfg_ctrl_flush,
  input  logic              Cfg_ctrl_err_clr,
  input  logic [ADDR_W:0]   Cfg_ctrl_thresh,
  output logic [DATA_W-1:0] FIFO_data_payload,
  output logic              FIFO_ctrl_empty,
  input  logic              STM_ctrl_FIFO_r_en,
  output logic              FIFO_ctrl_full,
  output logic [ADDR_W:0]   FIFO_ctrl_count,
  output logic              FIFO_ctrl_overflow,
  output logic              FIFO_ctrl_underflow,
  output logic              Int_tx_low
);

  localparam logic [ADDR_W:0] DepthC = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              low_q, low_d;

  logic wr_acc, pop_acc, ovf_set, udf_set;

  // Handshake decode. A pop frees a slot in the same cycle, so a write
  // into a full buffer is still accepted when paired with a pop. Flush
  // blocks both operations and any error detection for that cycle.
  always_comb begin
    pop_acc = STM_ctrl_FIFO_r_en & ~empty_q & ~Cfg_ctrl_flush;
    wr_acc  = Bus_ctrl_w_en & (~full_q | pop_acc) & ~Cfg_ctrl_flush;
    ovf_set = Bus_ctrl_w_en & full_q & ~pop_acc & ~Cfg_ctrl_flush;
    udf_set = STM_ctrl_FIFO_r_en & empty_q & ~Cfg_ctrl_flush;
  end

  // Next-state for pointers, occupancy and status. Flags are derived from
  // the next count so that count/full/empty are always mutually consistent.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Cfg_ctrl_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, pop_acc};
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DepthC);
    low_d   = (count_d <= Cfg_ctrl_thresh);
    // A fresh error in the same cycle as a clear must survive.
    ovf_d   = ovf_set ? 1'b1 : (Cfg_ctrl_err_clr ? 1'b0 : ovf_q);
    udf_d   = udf_set ? 1'b1 : (Cfg_ctrl_err_clr ? 1'b0 : udf_q);
  end

  // Control and status registers.
  always_ff @(posedge glb_clk or posedge glb_rst) begin
    if (glb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      low_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      low_q    <= low_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge glb_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= Bus_data_wdata;
  end

  // Head of queue falls through; forced to zero while empty so the reset
  // value is defined without clearing the array.
  assign FIFO_data_payload   = empty_q ? '0 : mem_q[rd_ptr_q];
  assign FIFO_ctrl_empty     = empty_q;
  assign FIFO_ctrl_full      = full_q;
  assign FIFO_ctrl_count     = count_q;
  assign FIFO_ctrl_overflow  = ovf_q;
  assign FIFO_ctrl_underflow = udf_q;
  assign Int_tx_low          = low_q;

endmodule
